// File: rtl/noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : noc_local_ni
// Purpose  : Local network interface between a processing core and the local
//            port of a mesh router tile. The TX path packs core requests into
//            16-bit single-flit packets {payload, dest_x, dest_y} and injects
//            them under credit-based flow control. The RX path buffers ejected
//            flits in a FWFT FIFO with a registered head, presents them to the
//            core, and returns one credit per consumed flit.
// Ports    : clk, rst (async, active-high)
//            core TX   : tx_valid, tx_ready, tx_dest_x, tx_dest_y, tx_payload
//            router TX : net_tx_data, net_tx_enable, net_tx_credit
//            router RX : net_rx_data, net_rx_enable, net_rx_credit
//            core RX   : rx_valid, rx_ready, rx_data, rx_misroute
//            status    : tx_count, rx_count, err[1:0] (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module noc_local_ni #(
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_dest_x,
    input  logic [3:0]  tx_dest_y,
    input  logic [7:0]  tx_payload,
    output logic [15:0] net_tx_data,
    output logic        net_tx_enable,
    input  logic        net_tx_credit,
    input  logic [15:0] net_rx_data,
    input  logic        net_rx_enable,
    output logic        net_rx_credit,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] rx_data,
    output logic        rx_misroute,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [1:0]  err
);

    localparam int              CW         = $clog2(CREDITS + 1);
    localparam int              AW         = $clog2(RX_DEPTH);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(CREDITS);
    localparam logic [7:0]      MY_ADDR    = {4'(XCOORD), 4'(YCOORD)};

    // ---------------- state ----------------
    logic [CW-1:0] credit_q,        credit_d;
    logic          tx_ready_q,      tx_ready_d;
    logic [15:0]   net_tx_data_q,   net_tx_data_d;
    logic          net_tx_enable_q, net_tx_enable_d;
    logic [15:0]   tx_count_q,      tx_count_d;
    logic [1:0]    err_q,           err_d;
    logic [AW:0]   wr_ptr_q,        wr_ptr_d;
    logic [AW:0]   rd_ptr_q,        rd_ptr_d;
    logic          rx_valid_q,      rx_valid_d;
    logic [15:0]   rx_data_q,       rx_data_d;
    logic          net_rx_credit_q, net_rx_credit_d;
    logic [15:0]   rx_count_q,      rx_count_d;
    logic [15:0]   mem_q [RX_DEPTH];

    logic tx_accept;
    logic rx_pop;
    logic rx_full;
    logic rx_wr;

    always_comb begin
        // ---------------- TX path ----------------
        tx_accept     = tx_valid && tx_ready_q;
        credit_d      = credit_q;
        err_d         = err_q;
        case ({net_tx_credit, tx_accept})
            2'b10: begin
                // A return beyond the router FIFO depth means the router
                // handed back more credits than flits we sent.
                if (credit_q == CREDIT_MAX) begin
                    err_d[0] = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
        // Registered ready follows the next counter value, so it never
        // depends combinationally on tx_valid.
        tx_ready_d      = (credit_d != '0);
        net_tx_enable_d = tx_accept;
        net_tx_data_d   = tx_accept ? {tx_payload, tx_dest_x, tx_dest_y} : net_tx_data_q;
        tx_count_d      = tx_count_q + {15'd0, tx_accept};

        // ---------------- RX path ----------------
        rx_pop  = rx_valid_q && rx_ready;
        rx_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // A pop on the same edge frees a slot, so a write while full is kept.
        rx_wr   = net_rx_enable && (!rx_full || rx_pop);
        if (net_rx_enable && !rx_wr) begin
            err_d[1] = 1'b1;
        end
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, rx_wr};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rx_pop};
        rx_valid_d = (wr_ptr_d != rd_ptr_d);
        // Registered head: if the new head slot is the one being written this
        // edge (buffer empty after the pop), bypass the incoming flit.
        rx_data_d  = rx_data_q;
        if (rx_valid_d) begin
            if (rx_wr && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                rx_data_d = net_rx_data;
            end else begin
                rx_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
        net_rx_credit_d = rx_pop;
        rx_count_d      = rx_count_q + {15'd0, rx_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q        <= CREDIT_MAX;
            tx_ready_q      <= 1'b0;
            net_tx_data_q   <= 16'd0;
            net_tx_enable_q <= 1'b0;
            tx_count_q      <= 16'd0;
            err_q           <= 2'b00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rx_valid_q      <= 1'b0;
            rx_data_q       <= 16'd0;
            net_rx_credit_q <= 1'b0;
            rx_count_q      <= 16'd0;
        end else begin
            credit_q        <= credit_d;
            tx_ready_q      <= tx_ready_d;
            net_tx_data_q   <= net_tx_data_d;
            net_tx_enable_q <= net_tx_enable_d;
            tx_count_q      <= tx_count_d;
            err_q           <= err_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rx_valid_q      <= rx_valid_d;
            rx_data_q       <= rx_data_d;
            net_rx_credit_q <= net_rx_credit_d;
            rx_count_q      <= rx_count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (rx_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= net_rx_data;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign net_tx_data   = net_tx_data_q;
    assign net_tx_enable = net_tx_enable_q;
    assign net_rx_credit = net_rx_credit_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_misroute   = rx_valid_q && (rx_data_q[7:0] != MY_ADDR);
    assign tx_count      = tx_count_q;
    assign rx_count      = rx_count_q;
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_local_ni
// Purpose  : Directed self-checking bench for noc_local_ni (XCOORD=1,
//            YCOORD=3, CREDITS=4, RX_DEPTH=4). Inputs change 1 time unit
//            after the rising edge; outputs are sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [3:0]  tx_dest_x = 4'd2;
    logic [3:0]  tx_dest_y = 4'd1;
    logic [7:0]  tx_payload = 8'hA5;
    logic [15:0] net_tx_data;
    logic        net_tx_enable;
    logic        net_tx_credit = 1'b0;
    logic [15:0] net_rx_data = 16'd0;
    logic        net_rx_enable = 1'b0;
    logic        net_rx_credit;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] rx_data;
    logic        rx_misroute;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [1:0]  err;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int pulses;

    always #5 clk = ~clk;

    noc_local_ni #(
        .XCOORD   (1),
        .YCOORD   (3),
        .CREDITS  (4),
        .RX_DEPTH (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_dest_x     (tx_dest_x),
        .tx_dest_y     (tx_dest_y),
        .tx_payload    (tx_payload),
        .net_tx_data   (net_tx_data),
        .net_tx_enable (net_tx_enable),
        .net_tx_credit (net_tx_credit),
        .net_rx_data   (net_rx_data),
        .net_rx_enable (net_rx_enable),
        .net_rx_credit (net_rx_credit),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_misroute   (rx_misroute),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles and counts net_tx_enable pulses, checking each flit.
    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (net_tx_enable) begin
                cnt++;
                chk("tx_flit", {16'd0, net_tx_data}, 32'h0000A521);
            end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_tx_ready",  {31'd0, tx_ready},      0);
        chk("rst_tx_en",     {31'd0, net_tx_enable}, 0);
        chk("rst_tx_data",   {16'd0, net_tx_data},   0);
        chk("rst_rx_valid",  {31'd0, rx_valid},      0);
        chk("rst_rx_data",   {16'd0, rx_data},       0);
        chk("rst_rx_credit", {31'd0, net_rx_credit}, 0);
        chk("rst_counts",    {tx_count, rx_count},   0);
        chk("rst_err",       {30'd0, err},           0);
        rst = 1'b0;
        chk("ready_pre_edge", {31'd0, tx_ready}, 0);
        tick();
        chk("ready_post_edge", {31'd0, tx_ready}, 1);

        // ---------------- burst until credits exhausted ----------------
        tx_valid = 1'b1;
        run_count(8, pulses);
        chk("burst_pulses", pulses, 4);
        chk("burst_ready",  {31'd0, tx_ready}, 0);
        chk("burst_count",  {16'd0, tx_count}, 4);
        chk("hold_data",    {16'd0, net_tx_data}, 32'h0000A521);

        // ---------------- single credit return ----------------
        net_tx_credit = 1'b1;
        tick();
        net_tx_credit = 1'b0;
        chk("cred_ready_up", {31'd0, tx_ready}, 1);
        chk("cred_no_en",    {31'd0, net_tx_enable}, 0);
        tick();
        chk("cred_en",       {31'd0, net_tx_enable}, 1);
        chk("cred_ready_dn", {31'd0, tx_ready}, 0);
        chk("cred_count",    {16'd0, tx_count}, 5);
        tick();
        chk("cred_en_gone",  {31'd0, net_tx_enable}, 0);

        // ---------------- simultaneous accept + return at credit 2 ----------------
        tx_valid = 1'b0;
        net_tx_credit = 1'b1;
        tick();
        tick();
        tx_valid = 1'b1;
        run_count(10, pulses);
        tx_valid = 1'b0;
        net_tx_credit = 1'b0;
        chk("sim_pulses", pulses, 10);
        chk("sim_err",    {30'd0, err}, 0);
        tick();
        tx_valid = 1'b1;
        run_count(4, pulses);
        tx_valid = 1'b0;
        chk("sim_credit_left", pulses, 2);
        chk("sim_count", {16'd0, tx_count}, 17);

        // ---------------- credit overflow ----------------
        net_tx_credit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_not_yet", {30'd0, err}, 0);
        tick();
        net_tx_credit = 1'b0;
        chk("ovf_err", {30'd0, err}, 1);
        tx_valid = 1'b1;
        run_count(6, pulses);
        tx_valid = 1'b0;
        chk("ovf_saturated", pulses, 4);
        chk("ovf_count", {16'd0, tx_count}, 21);
        tick();
        chk("ovf_sticky", {30'd0, err}, 1);

        // ---------------- RX delivery and misroute ----------------
        net_rx_enable = 1'b1;
        net_rx_data = 16'h1113;
        tick();
        chk("rx_valid_1",    {31'd0, rx_valid}, 1);
        chk("rx_data_1",     {16'd0, rx_data}, 32'h1113);
        chk("rx_misroute_1", {31'd0, rx_misroute}, 0);
        net_rx_data = 16'h2222;
        tick();
        net_rx_enable = 1'b0;
        chk("rx_head_hold",  {16'd0, rx_data}, 32'h1113);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_credit_1",   {31'd0, net_rx_credit}, 1);
        chk("rx_data_2",     {16'd0, rx_data}, 32'h2222);
        chk("rx_misroute_2", {31'd0, rx_misroute}, 1);
        chk("rx_count_1",    {16'd0, rx_count}, 1);
        tick();
        chk("rx_credit_off", {31'd0, net_rx_credit}, 0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_empty",      {31'd0, rx_valid}, 0);
        chk("rx_mis_empty",  {31'd0, rx_misroute}, 0);
        chk("rx_count_2",    {16'd0, rx_count}, 2);

        // ---------------- reset mid-operation ----------------
        tx_valid = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_en", {31'd0, net_tx_enable}, 0);
        chk("mid_rst_err",   {30'd0, err}, 0);
        chk("mid_rst_count", {16'd0, tx_count}, 0);
        tx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- RX full, write+pop, overflow, order ----------------
        net_rx_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_rx_data = 16'h0013 | (16'(i) << 8);
            tick();
        end
        net_rx_data = 16'h0413;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("full_wp_err",    {30'd0, err}, 0);
        chk("full_wp_head",   {16'd0, rx_data}, 32'h0113);
        chk("full_wp_credit", {31'd0, net_rx_credit}, 1);
        net_rx_data = 16'h0513;
        tick();
        net_rx_enable = 1'b0;
        chk("full_drop_err",  {30'd0, err}, 2);
        for (int i = 1; i < 5; i++) begin
            chk("drain_valid", {31'd0, rx_valid}, 1);
            chk("drain_data",  {16'd0, rx_data}, 32'h0013 | (i << 8));
            rx_ready = 1'b1;
            tick();
        end
        rx_ready = 1'b0;
        chk("drain_empty", {31'd0, rx_valid}, 0);
        chk("drain_count", {16'd0, rx_count}, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
`default_nettype wire
